// File: rtl/uart_pkg.sv
// ============================================================================
// uart_pkg : FSM encodings and line levels shared by uart_tx / uart_rx
// Rev 1.0
// ============================================================================
`default_nettype none

package uart_pkg;

    localparam logic [2:0] ST_IDLE   = 3'd0;
    localparam logic [2:0] ST_START  = 3'd1;
    localparam logic [2:0] ST_DATA   = 3'd2;
    localparam logic [2:0] ST_PARITY = 3'd3;
    localparam logic [2:0] ST_STOP   = 3'd4;

    localparam logic UART_IDLE_LVL  = 1'b1;
    localparam logic UART_START_LVL = 1'b0;

endpackage : uart_pkg

`default_nettype wire

// File: rtl/uart_tx.sv
// ============================================================================
// uart_tx : baud-tick driven UART transmitter with one-entry holding register
// Optional parity bit enabled by defining UART_TX_PARITY_EN.
// Rev 1.0
// ============================================================================
`default_nettype none

module uart_tx
    import uart_pkg::*;
#(
    parameter int DATA_BITS  = 8,
    parameter int STOP_BITS  = 1,
    parameter int PARITY_ODD = 0
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 baud_tick,
    input  logic [DATA_BITS-1:0] tx_data,
    input  logic                 tx_valid,
    output logic                 tx_ready,
    output logic                 tx,
    output logic                 tx_busy
);

    localparam int             BCW         = $clog2(DATA_BITS);
    localparam logic [BCW-1:0] C_LAST_BIT  = BCW'(DATA_BITS - 1);
    localparam logic           C_LAST_STOP = (STOP_BITS == 2);

    logic [2:0]           r_state;
    logic [2:0]           w_state_n;
    logic [DATA_BITS-1:0] r_shift;
    logic [DATA_BITS-1:0] w_shift_n;
    logic [DATA_BITS-1:0] r_hold;
    logic                 r_hold_valid;
    logic [BCW-1:0]       r_bit_cnt;
    logic [BCW-1:0]       w_bit_cnt_n;
    logic                 r_stop_cnt;
    logic                 w_stop_cnt_n;
    logic                 r_tx;
    logic                 w_tx_n;
    logic                 w_load;
    logic                 w_accept;

`ifdef UART_TX_PARITY_EN
    logic r_parity;
    logic w_parity_n;
`else
    logic w_unused_parity_odd;
    assign w_unused_parity_odd = (PARITY_ODD != 0);
`endif

    assign w_accept = tx_valid && !r_hold_valid;

    always_comb begin
        w_state_n    = r_state;
        w_shift_n    = r_shift;
        w_bit_cnt_n  = r_bit_cnt;
        w_stop_cnt_n = r_stop_cnt;
        w_load       = 1'b0;
`ifdef UART_TX_PARITY_EN
        w_parity_n   = r_parity;
`endif
        if (baud_tick) begin
            case (r_state)
                ST_IDLE: begin
                    if (r_hold_valid) begin
                        w_load    = 1'b1;
                        w_state_n = ST_START;
                    end
                end
                ST_START: begin
                    w_state_n   = ST_DATA;
                    w_bit_cnt_n = '0;
                end
                ST_DATA: begin
                    if (r_bit_cnt == C_LAST_BIT) begin
`ifdef UART_TX_PARITY_EN
                        w_state_n = ST_PARITY;
`else
                        w_state_n = ST_STOP;
`endif
                        w_stop_cnt_n = 1'b0;
                    end else begin
                        w_shift_n   = {1'b0, r_shift[DATA_BITS-1:1]};
                        w_bit_cnt_n = r_bit_cnt + BCW'(1);
                    end
                end
`ifdef UART_TX_PARITY_EN
                ST_PARITY: begin
                    w_state_n    = ST_STOP;
                    w_stop_cnt_n = 1'b0;
                end
`endif
                ST_STOP: begin
                    if (r_stop_cnt == C_LAST_STOP) begin
                        // Chain straight into the next frame when a word is waiting.
                        if (r_hold_valid) begin
                            w_load    = 1'b1;
                            w_state_n = ST_START;
                        end else begin
                            w_state_n = ST_IDLE;
                        end
                    end else begin
                        w_stop_cnt_n = r_stop_cnt + 1'b1;
                    end
                end
                default: w_state_n = ST_IDLE;
            endcase
        end
        if (w_load) begin
            w_shift_n  = r_hold;
`ifdef UART_TX_PARITY_EN
            w_parity_n = (^r_hold) ^ (PARITY_ODD != 0);
`endif
        end
    end

    // Line level follows the state being entered so tx moves one clk after the tick.
    always_comb begin
        w_tx_n = UART_IDLE_LVL;
        case (w_state_n)
            ST_START:  w_tx_n = UART_START_LVL;
            ST_DATA:   w_tx_n = w_shift_n[0];
`ifdef UART_TX_PARITY_EN
            ST_PARITY: w_tx_n = w_parity_n;
`endif
            default:   w_tx_n = UART_IDLE_LVL;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= ST_IDLE;
            r_shift      <= '0;
            r_hold       <= '0;
            r_hold_valid <= 1'b0;
            r_bit_cnt    <= '0;
            r_stop_cnt   <= 1'b0;
            r_tx         <= UART_IDLE_LVL;
`ifdef UART_TX_PARITY_EN
            r_parity     <= 1'b0;
`endif
        end else begin
            r_state    <= w_state_n;
            r_shift    <= w_shift_n;
            r_bit_cnt  <= w_bit_cnt_n;
            r_stop_cnt <= w_stop_cnt_n;
            r_tx       <= w_tx_n;
`ifdef UART_TX_PARITY_EN
            r_parity   <= w_parity_n;
`endif
            if (w_accept) begin
                r_hold       <= tx_data;
                r_hold_valid <= 1'b1;
            end else if (w_load) begin
                r_hold_valid <= 1'b0;
            end
        end
    end

    assign tx_ready = !r_hold_valid;
    assign tx       = r_tx;
    assign tx_busy  = (r_state != ST_IDLE);

endmodule : uart_tx

`default_nettype wire
